multicycle_controller: RTL and testbench

Main control unit for the multi-cycle RV32I datapath; successor to the single-cycle opcode decoder. A Moore FSM sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and drives all datapath enables and mux selects. It waits on a ready handshake from the shared instruction/data memory and traps on illegal opcodes or memory timeouts. A retired-instruction counter is included.

---
 rtl/mc_ctrl_pkg.sv | 68 ++++++
 rtl/mc_ctrl_if.sv | 36 +++
 rtl/mc_ctrl_decode.sv | 36 +++
 rtl/multicycle_controller.sv | 199 +++++++++++++++++++
 tb/tb_multicycle_controller.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared opcodes, state/class enums and control-field encodings for the
// multi-cycle RV32I control unit.
package mc_ctrl_pkg;

    // RV32I major opcodes (IR[6:0])
    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_IARITH = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_TRAP
    } state_t;

    typedef enum logic [3:0] {
        CLS_R,
        CLS_IARITH,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_JAL,
        CLS_JALR,
        CLS_LUI,
        CLS_AUIPC
    } cls_t;

    // pc_src
    localparam logic [1:0] PC_ALU      = 2'b00;
    localparam logic [1:0] PC_ALUOUT   = 2'b01;
    localparam logic [1:0] PC_ALU_CLR0 = 2'b10;

    // alu_src_a
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_RS1   = 2'b01;
    localparam logic [1:0] SRCA_OLDPC = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    // alu_src_b
    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    // alu_op
    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

    // wb_sel
    localparam logic [1:0] WB_ALUOUT = 2'b00;
    localparam logic [1:0] WB_MDR    = 2'b01;
    localparam logic [1:0] WB_PC4    = 2'b10;

    // trap_cause
    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

endpackage

// File: rtl/mc_ctrl_if.sv
// Controller <-> datapath/memory signal bundle. The controller is the master.
interface mc_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic [6:0]       opcode;
    logic             mem_ready;
    logic             br_taken;
    logic             pc_write;
    logic [1:0]       pc_src;
    logic             ir_write;
    logic             iord;
    logic             mem_read;
    logic             mem_write;
    logic [1:0]       alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic             reg_write;
    logic [1:0]       wb_sel;
    logic             trap;
    logic [1:0]       trap_cause;
    logic [CNT_W-1:0] instret;

    modport master (
        input  opcode, mem_ready, br_taken,
        output pc_write, pc_src, ir_write, iord, mem_read, mem_write,
               alu_src_a, alu_src_b, alu_op, reg_write, wb_sel,
               trap, trap_cause, instret
    );

    modport slave (
        output opcode, mem_ready, br_taken,
        input  pc_write, pc_src, ir_write, iord, mem_read, mem_write,
               alu_src_a, alu_src_b, alu_op, reg_write, wb_sel,
               trap, trap_cause, instret
    );
endinterface

// File: rtl/mc_ctrl_decode.sv
// Opcode to instruction-class mapping with an illegal-opcode flag.
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
#(
    parameter bit EN_UPPER = 1'b1
) (
    input  logic [6:0] opcode,
    output cls_t       cls,
    output logic       illegal
);

    // Classify the opcode; LUI/AUIPC are illegal when upper-immediate support is off
    always_comb begin
        cls     = CLS_R;
        illegal = 1'b0;
        case (opcode)
            OPC_R:      cls = CLS_R;
            OPC_IARITH: cls = CLS_IARITH;
            OPC_LOAD:   cls = CLS_LOAD;
            OPC_STORE:  cls = CLS_STORE;
            OPC_BRANCH: cls = CLS_BRANCH;
            OPC_JAL:    cls = CLS_JAL;
            OPC_JALR:   cls = CLS_JALR;
            OPC_LUI: begin
                cls     = CLS_LUI;
                illegal = !EN_UPPER;
            end
            OPC_AUIPC: begin
                cls     = CLS_AUIPC;
                illegal = !EN_UPPER;
            end
            default:    illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I main control FSM: FETCH/DECODE/EXEC/MEM/WB with a sticky
// TRAP state, memory wait timeout and a retired-instruction counter.
module multicycle_controller
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32,
    parameter bit          EN_UPPER    = 1'b1
) (
    input logic       clk,
    input logic       reset,
    mc_ctrl_if.master bus
);

    // Counter only needs to hold MEM_TIMEOUT-1: the limit is hit on the last waiting cycle
    localparam int unsigned WAIT_W  = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
    localparam int unsigned TO_LAST = (MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1;

    state_t             state, state_next;
    cls_t               cls_q, dec_cls;
    logic               dec_illegal;
    logic [WAIT_W-1:0]  wait_cnt;
    logic               wait_expired;
    logic [1:0]         cause_q, cause_next;
    logic [CNT_W-1:0]   instret_q;
    logic               retire;

    logic               pc_write, ir_write, iord, mem_read, mem_write, reg_write;
    logic [1:0]         pc_src, alu_src_a, alu_src_b, alu_op, wb_sel;

    mc_ctrl_decode #(.EN_UPPER(EN_UPPER)) u_decode (
        .opcode  (bus.opcode),
        .cls     (dec_cls),
        .illegal (dec_illegal)
    );

    // mem_ready arriving on the limit cycle wins, since it is checked first below
    assign wait_expired = (MEM_TIMEOUT != 0) && (wait_cnt == WAIT_W'(TO_LAST));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_FETCH;
        else       state <= state_next;
    end

    // Next-state and control outputs from state, latched class and handshakes
    always_comb begin
        state_next = state;
        pc_write   = 1'b0;
        pc_src     = PC_ALU;
        ir_write   = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALUOP_ADD;
        reg_write  = 1'b0;
        wb_sel     = WB_ALUOUT;
        retire     = 1'b0;
        cause_next = CAUSE_NONE;
        case (state)
            ST_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                if (bus.mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    state_next = ST_DECODE;
                end else if (wait_expired) begin
                    state_next = ST_TRAP;
                    cause_next = CAUSE_TIMEOUT;
                end
            end
            ST_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                if (dec_illegal) begin
                    state_next = ST_TRAP;
                    cause_next = CAUSE_ILLEGAL;
                end else begin
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_next = ST_WB;
                case (cls_q)
                    CLS_R: begin
                        alu_src_a = SRCA_RS1;
                        alu_op    = ALUOP_FUNCT;
                    end
                    CLS_IARITH: begin
                        alu_src_a = SRCA_RS1;
                        alu_src_b = SRCB_IMM;
                        alu_op    = ALUOP_FUNCT;
                    end
                    CLS_LOAD, CLS_STORE: begin
                        alu_src_a  = SRCA_RS1;
                        alu_src_b  = SRCB_IMM;
                        state_next = ST_MEM;
                    end
                    CLS_BRANCH: begin
                        alu_src_a  = SRCA_RS1;
                        alu_op     = ALUOP_BRANCH;
                        pc_write   = bus.br_taken;
                        pc_src     = PC_ALUOUT;
                        retire     = 1'b1;
                        state_next = ST_FETCH;
                    end
                    CLS_JAL: begin
                        pc_write = 1'b1;
                        pc_src   = PC_ALUOUT;
                    end
                    CLS_JALR: begin
                        alu_src_a = SRCA_RS1;
                        alu_src_b = SRCB_IMM;
                        pc_write  = 1'b1;
                        pc_src    = PC_ALU_CLR0;
                    end
                    CLS_LUI: begin
                        alu_src_a = SRCA_ZERO;
                        alu_src_b = SRCB_IMM;
                    end
                    CLS_AUIPC: begin
                        alu_src_a = SRCA_OLDPC;
                        alu_src_b = SRCB_IMM;
                    end
                    default: ;
                endcase
            end
            ST_MEM: begin
                iord      = 1'b1;
                mem_read  = (cls_q == CLS_LOAD);
                mem_write = (cls_q != CLS_LOAD);
                if (bus.mem_ready) begin
                    if (cls_q == CLS_LOAD) begin
                        state_next = ST_WB;
                    end else begin
                        retire     = 1'b1;
                        state_next = ST_FETCH;
                    end
                end else if (wait_expired) begin
                    state_next = ST_TRAP;
                    cause_next = CAUSE_TIMEOUT;
                end
            end
            ST_WB: begin
                reg_write  = 1'b1;
                retire     = 1'b1;
                state_next = ST_FETCH;
                if (cls_q == CLS_LOAD)                         wb_sel = WB_MDR;
                else if (cls_q == CLS_JAL || cls_q == CLS_JALR) wb_sel = WB_PC4;
            end
            ST_TRAP: ;
            default: state_next = ST_FETCH;
        endcase
    end

    // Latch the instruction class while in DECODE
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                   cls_q <= CLS_R;
        else if (state == ST_DECODE) cls_q <= dec_cls;
    end

    // Wait counter: cleared on any state change, counts cycles stalled in FETCH/MEM
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                      wait_cnt <= '0;
        else if (state_next != state)                   wait_cnt <= '0;
        else if (state == ST_FETCH || state == ST_MEM)  wait_cnt <= wait_cnt + WAIT_W'(1);
    end

    // Capture the trap cause on entry to TRAP
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                         cause_q <= CAUSE_NONE;
        else if (cause_next != CAUSE_NONE) cause_q <= cause_next;
    end

    // Retired-instruction counter, wraps naturally
    always_ff @(posedge clk or posedge reset) begin
        if (reset)       instret_q <= '0;
        else if (retire) instret_q <= instret_q + CNT_W'(1);
    end

    assign bus.pc_write   = pc_write;
    assign bus.pc_src     = pc_src;
    assign bus.ir_write   = ir_write;
    assign bus.iord       = iord;
    assign bus.mem_read   = mem_read;
    assign bus.mem_write  = mem_write;
    assign bus.alu_src_a  = alu_src_a;
    assign bus.alu_src_b  = alu_src_b;
    assign bus.alu_op     = alu_op;
    assign bus.reg_write  = reg_write;
    assign bus.wb_sel     = wb_sel;
    assign bus.trap       = (state == ST_TRAP);
    assign bus.trap_cause = cause_q;
    assign bus.instret    = instret_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: two instances share stimulus, A with
// defaults and B with MEM_TIMEOUT=0, CNT_W=4, EN_UPPER=0.
module tb_multicycle_controller;
    import mc_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] opcode;
    logic       mem_ready;
    logic       br_taken;

    always #5 clk = ~clk;

    mc_ctrl_if #(.CNT_W(32)) if_a ();
    mc_ctrl_if #(.CNT_W(4))  if_b ();

    assign if_a.opcode    = opcode;
    assign if_a.mem_ready = mem_ready;
    assign if_a.br_taken  = br_taken;
    assign if_b.opcode    = opcode;
    assign if_b.mem_ready = mem_ready;
    assign if_b.br_taken  = br_taken;

    multicycle_controller #(.MEM_TIMEOUT(16), .CNT_W(32), .EN_UPPER(1'b1)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (if_a.master)
    );

    multicycle_controller #(.MEM_TIMEOUT(0), .CNT_W(4), .EN_UPPER(1'b0)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (if_b.master)
    );

    typedef struct {
        logic [6:0] opc;
        logic       br;
        int         fw;      // wait cycles in FETCH
        int         mw;      // wait cycles in MEM
        int         cyc;     // expected total cycles
        int         rw_at;   // cycle index of reg_write (0 = never)
        logic [1:0] wb;
        int         pcw;     // cycles with pc_write
        int         iordc;   // cycles with iord
        int         memw;    // cycles with mem_write
        logic [7:0] exsig;   // {alu_src_a, alu_src_b, alu_op, pc_src} in EXEC
    } tv_t;

    int  checks = 0;
    int  errors = 0;
    tv_t tbl [12];
    tv_t sb [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic tv_t mk(input logic [6:0] opc, input logic br, input int fw, input int mw,
                               input int cyc, input int rw_at, input logic [1:0] wb, input int pcw,
                               input int iordc, input int memw, input logic [7:0] exsig);
        tv_t t;
        t.opc = opc;   t.br = br;       t.fw = fw;       t.mw = mw;     t.cyc = cyc;
        t.rw_at = rw_at; t.wb = wb;     t.pcw = pcw;     t.iordc = iordc;
        t.memw = memw; t.exsig = exsig;
        return t;
    endfunction

    task automatic do_reset();
        reset     = 1'b1;
        mem_ready = 1'b0;
        br_taken  = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Drive one instruction on A (called at posedge+1 of its first FETCH cycle)
    task automatic run_instr(input tv_t t, input string tag);
        int         fw, mw, cyc, rw_at, pcw, iordc, memw;
        logic [1:0] wb;
        logic [7:0] sig;
        logic [31:0] start;
        bit         done;
        tv_t        e;
        fw = t.fw; mw = t.mw; cyc = 0; rw_at = 0; pcw = 0; iordc = 0; memw = 0;
        wb = 2'b00; sig = 8'h00; done = 1'b0;
        opcode   = t.opc;
        br_taken = t.br;
        sb.push_back(t);
        start = if_a.instret;
        while (!done && cyc < 40) begin
            if (if_a.iord) begin
                mem_ready = (mw == 0);
                if (mw > 0) mw--;
            end else if (if_a.mem_read) begin
                mem_ready = (fw == 0);
                if (fw > 0) fw--;
            end else begin
                mem_ready = 1'b1;
            end
            @(negedge clk);
            cyc++;
            if (if_a.reg_write) begin
                rw_at = cyc;
                wb    = if_a.wb_sel;
            end
            if (if_a.pc_write)  pcw++;
            if (if_a.iord)      iordc++;
            if (if_a.mem_write) memw++;
            if (cyc == t.fw + 3) sig = {if_a.alu_src_a, if_a.alu_src_b, if_a.alu_op, if_a.pc_src};
            @(posedge clk);
            #1;
            if (if_a.instret != start) done = 1'b1;
        end
        e = sb.pop_front();
        chk({tag, " retired"}, 32'(done), 32'd1);
        chk({tag, " cycles"}, 32'(cyc), 32'(e.cyc));
        chk({tag, " reg_write cycle"}, 32'(rw_at), 32'(e.rw_at));
        chk({tag, " wb_sel"}, 32'(wb), 32'(e.wb));
        chk({tag, " pc_write count"}, 32'(pcw), 32'(e.pcw));
        chk({tag, " iord count"}, 32'(iordc), 32'(e.iordc));
        chk({tag, " mem_write count"}, 32'(memw), 32'(e.memw));
        chk({tag, " exec controls"}, 32'(sig), 32'(e.exsig));
        chk({tag, " instret"}, if_a.instret, start + 32'd1);
    endtask

    initial begin
        opcode   = OPC_R;
        reset    = 1'b1;
        mem_ready = 1'b0;
        br_taken = 1'b0;
        do_reset();

        // Reset state (mem_ready low)
        chk("rst mem_read", 32'(if_a.mem_read), 32'd1);
        chk("rst alu_src_b", 32'(if_a.alu_src_b), 32'd1);
        chk("rst alu_src_a", 32'(if_a.alu_src_a), 32'd0);
        chk("rst enables", 32'({if_a.pc_write, if_a.ir_write, if_a.iord, if_a.mem_write,
                                if_a.reg_write, if_a.trap}), 32'd0);
        chk("rst alu_op/wb_sel/pc_src", 32'({if_a.alu_op, if_a.wb_sel, if_a.pc_src}), 32'd0);
        chk("rst trap_cause", 32'(if_a.trap_cause), 32'd0);
        chk("rst instret", if_a.instret, 32'd0);
        chk("rst instret B", 32'(if_b.instret), 32'd0);

        //          opc         br  fw mw cyc rw wb  pcw iord memw exsig
        tbl[0]  = mk(OPC_R,      0, 0, 0, 4,  4, 2'd0, 1, 0, 0, 8'h48);
        tbl[1]  = mk(OPC_LOAD,   0, 2, 1, 8,  8, 2'd1, 1, 2, 0, 8'h60);
        tbl[2]  = mk(OPC_BRANCH, 1, 0, 0, 3,  0, 2'd0, 2, 0, 0, 8'h45);
        tbl[3]  = mk(OPC_BRANCH, 0, 0, 0, 3,  0, 2'd0, 1, 0, 0, 8'h45);
        tbl[4]  = mk(OPC_STORE,  0, 0, 2, 6,  0, 2'd0, 1, 3, 3, 8'h60);
        tbl[5]  = mk(OPC_IARITH, 0, 1, 0, 5,  5, 2'd0, 1, 0, 0, 8'h68);
        tbl[6]  = mk(OPC_JAL,    0, 0, 0, 4,  4, 2'd2, 2, 0, 0, 8'h01);
        tbl[7]  = mk(OPC_JALR,   0, 0, 0, 4,  4, 2'd2, 2, 0, 0, 8'h62);
        tbl[8]  = mk(OPC_LOAD,   0, 0, 0, 5,  5, 2'd1, 1, 1, 0, 8'h60);
        tbl[9]  = mk(OPC_R,      0, 3, 0, 7,  7, 2'd0, 1, 0, 0, 8'h48);
        tbl[10] = mk(OPC_AUIPC,  0, 0, 0, 4,  4, 2'd0, 1, 0, 0, 8'hA0);
        tbl[11] = mk(OPC_LUI,    0, 0, 0, 4,  4, 2'd0, 1, 0, 0, 8'hE0);
        for (int i = 0; i < 12; i++) run_instr(tbl[i], $sformatf("vec%0d", i));

        // B has no upper-immediate support: trapped at the AUIPC
        chk("B upper trap", 32'(if_b.trap), 32'd1);
        chk("B upper cause", 32'(if_b.trap_cause), 32'(CAUSE_ILLEGAL));
        chk("B instret before trap", 32'(if_b.instret), 32'd10);
        chk("B trap mem_read", 32'(if_b.mem_read), 32'd0);

        // Illegal opcode: sticky trap
        do_reset();
        opcode    = 7'b0000000;
        mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("illegal trap", 32'(if_a.trap), 32'd1);
        chk("illegal cause", 32'(if_a.trap_cause), 32'(CAUSE_ILLEGAL));
        for (int i = 0; i < 20; i++) begin
            mem_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk($sformatf("trap hold %0d", i),
                32'({if_a.trap, if_a.mem_read, if_a.mem_write, if_a.pc_write,
                     if_a.reg_write, if_a.ir_write}), 32'h20);
            @(posedge clk);
            #1;
        end
        chk("illegal instret", if_a.instret, 32'd0);
        do_reset();
        chk("trap exit by reset", 32'({if_a.trap, if_a.trap_cause}), 32'd0);

        // Fetch timeout: 16 stalled cycles trap A; B never times out
        opcode = OPC_R;
        repeat (15) @(posedge clk);
        #1;
        chk("timeout 15 no trap", 32'(if_a.trap), 32'd0);
        @(posedge clk);
        #1;
        chk("timeout 16 trap", 32'(if_a.trap), 32'd1);
        chk("timeout cause", 32'(if_a.trap_cause), 32'(CAUSE_TIMEOUT));
        repeat (30) @(posedge clk);
        #1;
        chk("B no timeout", 32'({if_b.trap, if_b.mem_read}), 32'd1);

        // mem_ready on exactly the 16th cycle succeeds
        do_reset();
        repeat (15) @(posedge clk);
        #1 mem_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("ready at limit no trap", 32'(if_a.trap), 32'd0);
        chk("ready at limit decode", 32'(if_a.alu_src_a), 32'(SRCA_OLDPC));

        // 17 retires: B wraps to 1
        do_reset();
        for (int i = 0; i < 17; i++) run_instr(tbl[0], $sformatf("wrap%0d", i));
        chk("wrap instret A", if_a.instret, 32'd17);
        chk("wrap instret B", 32'(if_b.instret), 32'd1);

        // Reset in MEM of a store aborts the write
        opcode    = OPC_STORE;
        mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 mem_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("store in MEM", 32'({if_a.iord, if_a.mem_write}), 32'd3);
        #2 reset = 1'b1;
        #1;
        chk("abort mem_write", 32'(if_a.mem_write), 32'd0);
        chk("abort fetch outputs", 32'({if_a.mem_read, if_a.iord, if_a.alu_src_b}), 32'b1001);
        chk("abort instret", if_a.instret, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        chk("post-abort no write", 32'(if_a.mem_write), 32'd0);
        chk("post-abort instret", if_a.instret, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
